// File: rtl/button_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : button_conditioner                                     |
// | Description : Synchronises and debounces a raw push-button pin and   |
// |               produces a clean level, press/release/long-press       |
// |               strobes and a wrapping press counter.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES   = 120000,
   parameter int LONG_PRESS_CYCLES = 12000000,
   parameter int ACTIVE_LOW        = 0,
   parameter int COUNT_WIDTH       = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   button_in,
   input  logic                   count_clear,
   output logic                   level,
   output logic                   pressed,
   output logic                   released,
   output logic                   long_press,
   output logic [COUNT_WIDTH-1:0] press_count
);

   localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                               DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
   localparam int CNT_WIDTH  = $clog2(MAX_CYCLES) + 1;

   localparam logic                 IDLE_LEVEL = (ACTIVE_LOW != 0);
   localparam logic [CNT_WIDTH-1:0] DEB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] LONG_LAST  = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_WAIT_PRESS   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } state_t;

   logic                 sync0;
   logic                 sync1;
   logic                 s;
   state_t               state;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] counter;
   logic [CNT_WIDTH-1:0] counter_nxt;
   logic                 long_fired;
   logic                 long_fired_nxt;
   logic                 level_nxt;
   logic                 pressed_nxt;
   logic                 released_nxt;
   logic                 long_press_nxt;

   // Two-flop synchroniser; resets to the idle pin level so reset never looks like a press
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync0 <= IDLE_LEVEL;
         sync1 <= IDLE_LEVEL;
      end else begin
         sync0 <= button_in;
         sync1 <= sync0;
      end
   end

   // Normalised pressed indication: 1 means the button is down regardless of pin polarity
   assign s = sync1 ^ IDLE_LEVEL;

   // State, timer and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_RELEASED;
         counter    <= '0;
         long_fired <= 1'b0;
         level      <= 1'b0;
         pressed    <= 1'b0;
         released   <= 1'b0;
         long_press <= 1'b0;
      end else begin
         state      <= state_nxt;
         counter    <= counter_nxt;
         long_fired <= long_fired_nxt;
         level      <= level_nxt;
         pressed    <= pressed_nxt;
         released   <= released_nxt;
         long_press <= long_press_nxt;
      end
   end

   // Next-state and output decode; the timer restarts on every state change
   always_comb begin
      state_nxt      = state;
      counter_nxt    = (counter == CNT_MAX) ? counter : counter + 1'b1;
      long_fired_nxt = long_fired;
      level_nxt      = level;
      pressed_nxt    = 1'b0;
      released_nxt   = 1'b0;
      long_press_nxt = 1'b0;
      case (state)
         ST_RELEASED: begin
            counter_nxt = '0;
            if (s) begin
               state_nxt = ST_WAIT_PRESS;
            end
         end
         ST_WAIT_PRESS: begin
            if (!s) begin
               state_nxt   = ST_RELEASED;
               counter_nxt = '0;
            end else if (counter == DEB_LAST) begin
               state_nxt   = ST_PRESSED;
               counter_nxt = '0;
               level_nxt   = 1'b1;
               pressed_nxt = 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!s) begin
               state_nxt   = ST_WAIT_RELEASE;
               counter_nxt = '0;
            end else if ((counter == LONG_LAST) && !long_fired) begin
               counter_nxt    = counter;
               long_press_nxt = 1'b1;
               long_fired_nxt = 1'b1;
            end
         end
         ST_WAIT_RELEASE: begin
            if (s) begin
               // Release bounce: back to held, long-press timer restarts but stays armed-off
               state_nxt   = ST_PRESSED;
               counter_nxt = '0;
            end else if (counter == DEB_LAST) begin
               state_nxt      = ST_RELEASED;
               counter_nxt    = '0;
               level_nxt      = 1'b0;
               released_nxt   = 1'b1;
               long_fired_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt   = ST_RELEASED;
            counter_nxt = '0;
         end
      endcase
   end

   // Press counter; a clear coinciding with a press keeps that press
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         press_count <= '0;
      end else if (count_clear) begin
         press_count <= pressed_nxt ? COUNT_WIDTH'(1) : '0;
      end else if (pressed_nxt) begin
         press_count <= press_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_button_conditioner                                  |
// | Description : Directed self-checking bench for button_conditioner    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_button_conditioner;

   localparam int DEB = 4;
   localparam int LP  = 20;
   localparam int CW  = 3;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          button_in = 1'b0;
   logic          count_clear = 1'b0;
   logic          level, pressed, released, long_press;
   logic [CW-1:0] press_count;

   logic          button_al = 1'b1;
   logic          level_al, pressed_al, released_al, long_press_al;
   logic [CW-1:0] press_count_al;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_press = 0, n_rel = 0, n_long = 0;
   int n_press_al = 0, n_rel_al = 0;
   int press_at = -1000, long_at = -2000;
   int b_press, b_rel, b_long;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(0), .COUNT_WIDTH(CW)
   ) dut (
      .clock(clock), .reset(reset), .button_in(button_in), .count_clear(count_clear),
      .level(level), .pressed(pressed), .released(released), .long_press(long_press),
      .press_count(press_count)
   );

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LP), .ACTIVE_LOW(1), .COUNT_WIDTH(CW)
   ) dut_al (
      .clock(clock), .reset(reset), .button_in(button_al), .count_clear(1'b0),
      .level(level_al), .pressed(pressed_al), .released(released_al),
      .long_press(long_press_al), .press_count(press_count_al)
   );

   always #5 clock = ~clock;

   // Cycle index of the most recent rising edge
   always @(posedge clock) cyc <= cyc + 1;

   // Strobe counters and timestamps sampled mid-cycle
   always @(negedge clock) begin
      if (pressed)     begin n_press++; press_at = cyc; end
      if (released)    n_rel++;
      if (long_press)  begin n_long++; long_at = cyc; end
      if (pressed_al)  n_press_al++;
      if (released_al) n_rel_al++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Clean press then clean release; returns with the design idle
   task automatic press_release();
      button_in = 1'b1;
      repeat (DEB + 3) tick();
      button_in = 1'b0;
      repeat (DEB + 4) tick();
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_level", 32'(level), 0);
      check("rst_pressed", 32'(pressed), 0);
      check("rst_released", 32'(released), 0);
      check("rst_long", 32'(long_press), 0);
      check("rst_count", 32'(press_count), 0);
      reset = 1'b0;
      repeat (3) tick();

      // 1: clean press, level/pressed after edge k+6
      button_in = 1'b1;
      tick();                       // edge k
      repeat (DEB + 1) tick();      // edge k+5
      check("t1_level_early", 32'(level), 0);
      check("t1_pressed_early", 32'(pressed), 0);
      tick();                       // edge k+6
      check("t1_level", 32'(level), 1);
      check("t1_pressed", 32'(pressed), 1);
      check("t1_count", 32'(press_count), 1);
      tick();
      check("t1_pressed_one_cycle", 32'(pressed), 0);
      check("t1_level_held", 32'(level), 1);
      repeat (3) tick();
      button_in = 1'b0;
      repeat (DEB + 4) tick();
      check("t1_release_level", 32'(level), 0);

      // 2: bounce pulses of 1, 2, 3 cycles
      b_press = n_press;
      button_in = 1'b1; tick(); button_in = 1'b0; tick();
      button_in = 1'b1; repeat (2) tick(); button_in = 1'b0; tick();
      button_in = 1'b1; repeat (3) tick(); button_in = 1'b0;
      repeat (8) tick();
      check("t2_bounce_level", 32'(level), 0);
      check("t2_bounce_nopress", 32'(n_press - b_press), 0);
      button_in = 1'b1;
      repeat (10) tick();
      check("t2_steady_level", 32'(level), 1);
      check("t2_steady_one_press", 32'(n_press - b_press), 1);
      button_in = 1'b0;
      repeat (DEB + 4) tick();

      // 3: long press with release glitch
      b_press = n_press; b_rel = n_rel; b_long = n_long;
      button_in = 1'b1;
      repeat (30) tick();
      button_in = 1'b0;
      repeat (2) tick();
      button_in = 1'b1;
      repeat (8) tick();
      check("t3_no_glitch_release", 32'(n_rel - b_rel), 0);
      check("t3_level_through_glitch", 32'(level), 1);
      check("t3_long_once", 32'(n_long - b_long), 1);
      check("t3_long_delay", 32'(long_at - press_at), 20);
      button_in = 1'b0;
      tick();                       // edge k'
      repeat (DEB + 1) tick();
      check("t3_released_early", 32'(released), 0);
      tick();
      check("t3_released", 32'(released), 1);
      check("t3_level_low", 32'(level), 0);
      tick();
      check("t3_rel_count", 32'(n_rel - b_rel), 1);
      check("t3_press_count_total", 32'(n_press - b_press), 1);
      check("t3_long_total", 32'(n_long - b_long), 1);
      check("t3_count", 32'(press_count), 3);

      // 4: count_clear alone, then wrap sequence
      count_clear = 1'b1; tick(); count_clear = 1'b0;
      check("t4_clear_alone", 32'(press_count), 0);
      for (int i = 1; i <= 8; i++) begin
         press_release();
         check($sformatf("t4_count_%0d", i), 32'(press_count), 32'(i % 8));
      end
      button_in = 1'b1;
      tick();                       // edge k
      repeat (DEB + 1) tick();      // edge k+5
      count_clear = 1'b1;
      tick();                       // edge k+6 carries both press and clear
      count_clear = 1'b0;
      check("t4_clear_with_press_strobe", 32'(pressed), 1);
      check("t4_clear_with_press", 32'(press_count), 1);
      button_in = 1'b0;
      repeat (DEB + 4) tick();

      // 5: active-low instance idle-high, then pressed by driving low
      check("t5_al_idle_nopress", 32'(n_press_al), 0);
      check("t5_al_idle_norel", 32'(n_rel_al), 0);
      check("t5_al_idle_level", 32'(level_al), 0);
      button_al = 1'b0;
      repeat (DEB + 2) tick();
      check("t5_al_early", 32'(pressed_al), 0);
      tick();
      check("t5_al_pressed", 32'(pressed_al), 1);
      check("t5_al_level", 32'(level_al), 1);
      check("t5_al_count", 32'(press_count_al), 1);

      // 6: reset while held in PRESSED
      button_in = 1'b1;
      repeat (DEB + 5) tick();
      check("t6_pre_level", 32'(level), 1);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_level", 32'(level), 0);
      check("t6_rst_count", 32'(press_count), 0);
      check("t6_rst_strobes", 32'({pressed, released, long_press}), 0);
      tick();
      reset = 1'b0;
      tick();                       // edge k
      repeat (DEB + 1) tick();
      check("t6_refire_early", 32'(pressed), 0);
      tick();
      check("t6_refire", 32'(pressed), 1);
      check("t6_refire_count", 32'(press_count), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute guard against a stalled run
   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Upstream conditioner for the GPIO push-button that feeds the shift-register stage.
- Synchronises the raw button pin to the system clock and removes contact bounce.
- Produces a clean debounced level plus single-cycle press, release and long-press strobes.
- Keeps a wrapping press counter for LED/debug display.
- Its debounced level is what the shift register samples on each shift strobe.

Parameters:
DEBOUNCE_CYCLES, 120000, consecutive stable clocks required to accept a change (10 ms at 12 MHz); legal range >= 2
LONG_PRESS_CYCLES, 12000000, clocks in PRESSED before long_press fires (1 s at 12 MHz); legal range > DEBOUNCE_CYCLES
ACTIVE_LOW, 0, 1 = pin reads 0 when the button is pressed
COUNT_WIDTH, 8, width of press_count

Ports:
clock  input  1  system clock, 12 MHz
reset  input  1  asynchronous reset, active-high
button_in  input  1  raw, asynchronous button pin
count_clear  input  1  synchronous clear of press_count
level  output  1  debounced state, 1 = pressed
pressed  output  1  one-cycle strobe on accepted press
released  output  1  one-cycle strobe on accepted release
long_press  output  1  one-cycle strobe, at most once per press
press_count  output  COUNT_WIDTH  number of accepted presses, wraps

Behaviour:
- Clocking and reset:
  - One clock domain, with all flops on the rising edge of clock.
  - Reset is asynchronous and active-high; the design is reset-clean when reset rises at any time.
- Reset values:
  - Both synchroniser flops reset to ACTIVE_LOW, the idle pin level.
  - State = RELEASED, counter = 0, long_fired = 0.
  - level, pressed, released, long_press = 0; press_count = 0.
- Synchroniser: two-flop chain sync0 <= button_in, sync1 <= sync0. Define s = sync1 XOR ACTIVE_LOW, so s = 1 means pressed.
- Counter: one internal counter, sized $clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)) + 1 bits and saturating. It is cleared on every state transition.
- State machine, evaluated every clock:
  - RELEASED:
    - s = 1 -> WAIT_PRESS, counter = 0.
  - WAIT_PRESS:
    - s = 0 -> RELEASED; bounce rejected, no strobe.
    - Otherwise, if counter == DEBOUNCE_CYCLES-1 -> PRESSED, with level <= 1 and pressed <= 1 for one cycle.
    - Otherwise counter++.
  - PRESSED:
    - s = 0 -> WAIT_RELEASE.
    - Otherwise, if counter == LONG_PRESS_CYCLES-1 and long_fired = 0 -> long_press <= 1 for one cycle, long_fired <= 1.
    - Otherwise counter++, saturating.
  - WAIT_RELEASE:
    - s = 1 -> PRESSED; the long-press timer restarts from 0 and long_fired is kept.
    - Otherwise, if counter == DEBOUNCE_CYCLES-1 -> RELEASED, with level <= 0, released <= 1 for one cycle, long_fired <= 0.
    - Otherwise counter++.
- Latency: let edge k be the first edge at which sync0 captures a pressed level. level and pressed are then visible after edge k+DEBOUNCE_CYCLES+2. Release follows the same rule.
- Strobes:
  - All outputs are registered; no combinational path from button_in.
  - pressed, released and long_press are never asserted in the same cycle.
  - level is constant in WAIT_PRESS and WAIT_RELEASE.
- press_count:
  - Increments by 1 in the cycle pressed is asserted and wraps 2^COUNT_WIDTH-1 -> 0.
  - count_clear alone -> 0 on the next edge.
  - count_clear together with a press increment -> 1; the press is never lost.
- Glitch shorter than DEBOUNCE_CYCLES in any WAIT state: no strobe, and level is unchanged.
- Reset asserted mid-debounce or mid-press:
  - All state returns to reset values immediately.
  - After reset is released, a button still held is re-debounced from RELEASED and produces a fresh pressed strobe.

Test Plan:
1. Bench params DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=0, COUNT_WIDTH=3 unless stated. Clean press held 10 cycles, first sampled at edge k -> level=1 and pressed=1 for exactly one cycle after edge k+6; press_count=1.
2. Bounce: pulses of 1, 2 and 3 cycles high separated by 1-cycle lows -> level stays 0, no pressed strobe. A following steady press -> exactly one pressed strobe.
3. Hold a press for 40 cycles -> exactly one long_press, 20 cycles after pressed. A 2-cycle release glitch at cycle 30 -> no released strobe and no second long_press. Final release -> released after DEBOUNCE_CYCLES+2 edges.
4. Nine clean presses -> press_count sequence 1..7, 0, 1 (wraps at 8). Raise count_clear in the same cycle as the 9th pressed strobe -> press_count=1.
5. ACTIVE_LOW=1, pin idle-high, reset run -> no strobes. Pin driven low steadily -> pressed strobe, level=1.
6. Assert reset while in PRESSED with the pin held -> all outputs 0 immediately. Release reset with the pin still held -> pressed re-fires after DEBOUNCE_CYCLES+2 edges and press_count=1.
